// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage register.
//   - ST_*           : 2-bit state encoding of the skid buffer (EMPTY/ONE/TWO)
//   - TNEW_MAX_DEF   : Tnew shown by an empty stage (default width 3)
//   - NOP_INSTR_DEF  : instruction word shown by an empty stage
//   - tnew_sat_dec() : Tnew decrement that saturates at zero
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0]  TNEW_MAX_DEF  = 3'd7;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Widest Tnew field the helper handles; callers cast to/from their width.
  localparam int TNEW_W_LIMIT = 8;

  function automatic logic [TNEW_W_LIMIT-1:0] tnew_sat_dec(
    input logic [TNEW_W_LIMIT-1:0] t
  );
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one {instr, pc, data, tnew} pipeline entry.
//   clk     : clock
//   load_i  : capture the *_i fields at the rising edge
//   instr_i, pc_i, data_i, tnew_i : entry contents to capture
//   instr_o, pc_o, data_o, tnew_o : currently held contents
// Payload is deliberately not reset; validity is tracked by the owner.
module pipe_entry_reg #(
  parameter int DATA_W = 32,
  parameter int TNEW_W = 3
) (
  input  logic              clk,
  input  logic              load_i,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TNEW_W-1:0] tnew_o
);

  logic [31:0]       instr_q;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] data_q;
  logic [TNEW_W-1:0] tnew_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      data_q  <= data_i;
      tnew_q  <= tnew_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;
  assign tnew_o  = tnew_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: 2-entry skid-buffer pipeline register, 1-cycle latency.
//   clk, reset (async, active low), flush (sync kill of all entries)
//   in_valid/in_ready  : upstream handshake (in_ready is registered)
//   in_instr, in_pc, in_data, in_tnew : incoming instruction fields
//   out_valid/out_ready: downstream handshake
//   out_instr, out_pc, out_data, out_tnew : head entry; NOP_INSTR/TNEW_MAX
//                        are shown on instr/tnew while the stage is empty
// Incoming Tnew is decremented (saturating at 0) once, on capture.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 TNEW_W    = 3,
  parameter logic [TNEW_W-1:0]  TNEW_MAX  = TNEW_W'(TNEW_MAX_DEF),
  parameter logic [31:0]        NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew
);

  logic [1:0] state_q, state_d;
  logic       in_ready_q;
  logic       in_xfer, out_xfer, valid_w;
  logic       head_load, skid_load, head_from_skid;

  logic [TNEW_W-1:0] tnew_cap;

  logic [31:0]       head_instr_d, head_pc_d, head_instr, head_pc;
  logic [DATA_W-1:0] head_data_d, head_data;
  logic [TNEW_W-1:0] head_tnew_d, head_tnew;
  logic [31:0]       skid_instr, skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic [TNEW_W-1:0] skid_tnew;

  assign valid_w  = (state_q != ST_EMPTY);
  assign in_xfer  = in_valid & in_ready_q & ~flush;   // flushed input is dropped
  assign out_xfer = valid_w & out_ready;
  assign tnew_cap = TNEW_W'(tnew_sat_dec(TNEW_W_LIMIT'(in_tnew)));

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_ONE;
            head_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;          // new entry replaces the departing head
          end else if (in_xfer) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            state_d        = ST_ONE;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered ready: derived from the state we are about to enter.
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Promotion copies the skid entry verbatim so its Tnew is not decremented twice.
  assign head_instr_d = head_from_skid ? skid_instr : in_instr;
  assign head_pc_d    = head_from_skid ? skid_pc    : in_pc;
  assign head_data_d  = head_from_skid ? skid_data  : in_data;
  assign head_tnew_d  = head_from_skid ? skid_tnew  : tnew_cap;

  pipe_entry_reg #(.DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_head (
    .clk     (clk),
    .load_i  (head_load),
    .instr_i (head_instr_d),
    .pc_i    (head_pc_d),
    .data_i  (head_data_d),
    .tnew_i  (head_tnew_d),
    .instr_o (head_instr),
    .pc_o    (head_pc),
    .data_o  (head_data),
    .tnew_o  (head_tnew)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_skid (
    .clk     (clk),
    .load_i  (skid_load),
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .data_i  (in_data),
    .tnew_i  (tnew_cap),
    .instr_o (skid_instr),
    .pc_o    (skid_pc),
    .data_o  (skid_data),
    .tnew_o  (skid_tnew)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = valid_w;
  assign out_instr = valid_w ? head_instr : NOP_INSTR;
  assign out_tnew  = valid_w ? head_tnew  : TNEW_MAX;
  assign out_pc    = head_pc;
  assign out_data  = head_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg. Two instances share
// the stimulus: the default configuration and a DATA_W=96/TNEW_W=2 one.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [95:0] in_data;
  logic [2:0]  in_tnew;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_instr, a_out_pc, a_out_data;
  logic [2:0]  a_out_tnew;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_instr, b_out_pc;
  logic [95:0] b_out_data;
  logic [1:0]  b_out_tnew;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_data   (in_data[31:0]),
    .in_tnew   (in_tnew),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_instr (a_out_instr),
    .out_pc    (a_out_pc),
    .out_data  (a_out_data),
    .out_tnew  (a_out_tnew)
  );

  pipe_stage_reg #(.DATA_W(96), .TNEW_W(2), .TNEW_MAX(2'd3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .in_tnew   (in_tnew[1:0]),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_instr (b_out_instr),
    .out_pc    (b_out_pc),
    .out_data  (b_out_data),
    .out_tnew  (b_out_tnew)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [2:0] tnew, input logic [95:0] data);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    in_tnew  = tnew;
    in_data  = data;
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, ".a_valid"}, 96'(a_out_valid), 96'd0);
    check_eq({tag, ".b_valid"}, 96'(b_out_valid), 96'd0);
    check_eq({tag, ".a_instr"}, 96'(a_out_instr), 96'd0);
    check_eq({tag, ".b_instr"}, 96'(b_out_instr), 96'd0);
    check_eq({tag, ".a_tnew"},  96'(a_out_tnew),  96'd7);
    check_eq({tag, ".b_tnew"},  96'(b_out_tnew),  96'd3);
    check_eq({tag, ".a_ready"}, 96'(a_in_ready),  96'd1);
    check_eq({tag, ".b_ready"}, 96'(b_in_ready),  96'd1);
    $display("txn %s: idle valid=%0d/%0d ready=%0d/%0d", tag, a_out_valid, b_out_valid,
             a_in_ready, b_in_ready);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [1:0] tnew, input logic [95:0] data);
    check_eq({tag, ".a_valid"}, 96'(a_out_valid), 96'd1);
    check_eq({tag, ".b_valid"}, 96'(b_out_valid), 96'd1);
    check_eq({tag, ".a_instr"}, 96'(a_out_instr), 96'(instr));
    check_eq({tag, ".b_instr"}, 96'(b_out_instr), 96'(instr));
    check_eq({tag, ".a_pc"},    96'(a_out_pc),    96'(pc));
    check_eq({tag, ".b_pc"},    96'(b_out_pc),    96'(pc));
    check_eq({tag, ".a_tnew"},  96'(a_out_tnew),  96'(tnew));
    check_eq({tag, ".b_tnew"},  96'(b_out_tnew),  96'(tnew));
    check_eq({tag, ".a_data"},  96'(a_out_data),  96'(data[31:0]));
    check_eq({tag, ".b_data"},  b_out_data,       data);
    $display("txn %s: out instr=%08h pc=%08h tnew=%0d data=%024h", tag, a_out_instr,
             a_out_pc, a_out_tnew, b_out_data);
  endtask

  task automatic expect_ready(input string tag, input logic exp);
    check_eq({tag, ".a_ready"}, 96'(a_in_ready), 96'(exp));
    check_eq({tag, ".b_ready"}, 96'(b_in_ready), 96'(exp));
  endtask

  localparam logic [95:0] DA = 96'hAAAA_0001_1111_0001_2222_0001;
  localparam logic [95:0] DB = 96'hBBBB_0002_1111_0002_2222_0002;
  localparam logic [95:0] DC = 96'hCCCC_0003_1111_0003_2222_0003;
  localparam logic [95:0] DD = 96'hDDDD_0004_1111_0004_2222_0004;

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 96'h0);
    tick(); tick();
    expect_idle("reset_held");
    reset = 1'b1;
    tick();
    expect_idle("reset_released");

    // Streaming with out_ready=1
    out_ready = 1'b1;
    drive(1'b1, 32'h8C01_0004, 32'h0000_3000, 3'd2, DA);
    tick();
    expect_head("stream_first", 32'h8C01_0004, 32'h0000_3000, 2'd1, DA);
    drive(1'b1, 32'h2001_0005, 32'h0000_3004, 3'd0, DB);
    tick();
    expect_head("stream_tnew0", 32'h2001_0005, 32'h0000_3004, 2'd0, DB);
    expect_ready("stream_ready", 1'b1);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 96'h0);
    tick();
    expect_idle("stream_drained");

    // Backpressure: A, B accepted, C held upstream
    out_ready = 1'b0;
    drive(1'b1, 32'hA000_0000, 32'h0000_4000, 3'd3, DA);
    tick();
    expect_head("bp_A_head", 32'hA000_0000, 32'h0000_4000, 2'd2, DA);
    expect_ready("bp_one_ready", 1'b1);
    drive(1'b1, 32'hB000_0000, 32'h0000_4004, 3'd2, DB);
    tick();
    drive(1'b1, 32'hC000_0000, 32'h0000_4008, 3'd1, DC);
    expect_ready("bp_C_presented", 1'b0);
    expect_head("bp_A_held", 32'hA000_0000, 32'h0000_4000, 2'd2, DA);
    tick();
    expect_ready("bp_still_full", 1'b0);
    expect_head("bp_A_held2", 32'hA000_0000, 32'h0000_4000, 2'd2, DA);
    out_ready = 1'b1;
    tick();
    expect_head("bp_B_out", 32'hB000_0000, 32'h0000_4004, 2'd1, DB);
    expect_ready("bp_ready_back", 1'b1);
    tick();
    expect_head("bp_C_out", 32'hC000_0000, 32'h0000_4008, 2'd0, DC);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 96'h0);
    tick();
    expect_idle("bp_drained");

    // Flush from TWO with D presented
    out_ready = 1'b0;
    drive(1'b1, 32'hE000_0000, 32'h0000_5000, 3'd1, DA);
    tick();
    drive(1'b1, 32'hF000_0000, 32'h0000_5004, 3'd1, DB);
    tick();
    expect_ready("flush_two_full", 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'hD000_0000, 32'h0000_5008, 3'd1, DD);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 96'h0);
    expect_idle("flush_from_two");
    out_ready = 1'b1;
    tick();
    expect_idle("flush_two_no_D");

    // Flush from ONE: here in_ready=1, so D really would transfer without flush
    out_ready = 1'b0;
    drive(1'b1, 32'hE100_0000, 32'h0000_6000, 3'd2, DA);
    tick();
    expect_head("flush_one_setup", 32'hE100_0000, 32'h0000_6000, 2'd1, DA);
    flush = 1'b1;
    drive(1'b1, 32'hD100_0000, 32'h0000_6004, 3'd2, DD);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 96'h0);
    expect_idle("flush_from_one");
    out_ready = 1'b1;
    tick();
    expect_idle("flush_one_no_D");

    // Asynchronous reset while in ONE
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'h0000_7000, 3'd3, DC);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0, 96'h0);
    expect_head("areset_setup", 32'h1234_5678, 32'h0000_7000, 2'd2, DC);
    #2;
    reset = 1'b0;
    #1;
    expect_idle("areset_immediate");
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    expect_idle("areset_released");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
